imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_word_assembler.sv | 49 ++++
 rtl/imem_boot_loader.sv | 129 ++++++++++++
 tb/tb_imem_boot_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    FIN,
    ERR
  } loader_state_e;

  localparam int BOOT_HDR_BYTES = 2;
  localparam int WORD_BYTES     = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/mips_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; word_valid pulses the
// cycle after the fourth byte of a word is taken.
module mips_word_assembler
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  phase_q, phase_d;
  logic        valid_q, valid_d;

  always_comb begin
    word_d    = word_q;
    phase_d   = phase_q;
    word_last = 1'b0;
    if (clr) begin
      phase_d = 2'd0;
    end else if (byte_en) begin
      word_d    = {word_q[23:0], byte_in};
      phase_d   = phase_q + 2'd1;
      word_last = (phase_q == 2'(WORD_BYTES - 1));
    end
    valid_d = word_last;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word_q  <= '0;
      phase_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory, then
// releases the processor from reset.
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  loader_state_e state_q, state_d;
  logic          hdr_cnt_q, hdr_cnt_d;
  logic [7:0]    hdr_hi_q, hdr_hi_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [31:0]   addr_q, addr_d;
  logic          cpu_rel_q, cpu_rel_d;

  logic          accept, restart, byte_en;
  logic [15:0]   hdr_n;
  logic [31:0]   asm_word;
  logic          asm_valid, asm_last;

  mips_word_assembler u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr        (restart),
    .byte_en    (byte_en),
    .byte_in    (in_byte),
    .word       (asm_word),
    .word_valid (asm_valid),
    .word_last  (asm_last)
  );

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    hdr_hi_d     = hdr_hi_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    cpu_rel_d    = 1'b0;

    in_ready = (state_q == HDR) || (state_q == DATA);
    accept   = in_valid && in_ready;
    byte_en  = accept && (state_q == DATA);
    restart  = start && ((state_q == IDLE) || (state_q == FIN) || (state_q == ERR));
    hdr_n    = {hdr_hi_q, in_byte};

    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        if (accept) begin
          if (hdr_cnt_q == 1'(BOOT_HDR_BYTES - 1)) begin
            hdr_cnt_d = 1'b0;
            n_d       = hdr_n;
            state_d   = ((hdr_n == 16'd0) || (int'(hdr_n) > DEPTH)) ? ERR : DATA;
          end else begin
            hdr_hi_d  = in_byte;
            hdr_cnt_d = 1'b1;
          end
        end
      end
      // word_count already reflects the word being written during the pulse
      DATA: if (asm_valid && (word_count_q == n_q)) state_d = FIN;
      FIN: begin
        if (start) state_d = HDR;
        else       cpu_rel_d = 1'b1;
      end
      ERR: if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase

    if (restart) begin
      word_count_d = 16'd0;
      addr_d       = BASE_ADDR;
      hdr_cnt_d    = 1'b0;
    end

    if (asm_last) begin
      word_count_d = word_count_q + 16'd1;
      addr_d       = word_addr(BASE_ADDR, word_count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= 1'b0;
      hdr_hi_q     <= 8'd0;
      n_q          <= 16'd0;
      word_count_q <= 16'd0;
      addr_q       <= BASE_ADDR;
      cpu_rel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_hi_q     <= hdr_hi_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
      cpu_rel_q    <= cpu_rel_d;
    end
  end

  assign imem_we     = asm_valid;
  assign imem_addr   = addr_q;
  assign imem_wdata  = asm_word;
  assign cpu_reset_n = cpu_rel_q;
  assign busy        = (state_q == HDR) || (state_q == DATA);
  assign done        = (state_q == FIN);
  assign error       = (state_q == ERR);
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: two loaders (base 0x0 and 0x400) share one byte stream.
module tb_imem_boot_loader;

  logic        clock = 1'b0;
  logic        reset_n, start, in_valid;
  logic [7:0]  in_byte;

  logic        in_ready, imem_we, cpu_reset_n, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  logic        b_in_ready, b_imem_we, b_cpu_reset_n, b_busy, b_done, b_error;
  logic [31:0] b_imem_addr, b_imem_wdata;
  logic [15:0] b_word_count;

  always #5 clock = ~clock;

  imem_boot_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  imem_boot_loader #(.DEPTH(256), .BASE_ADDR(32'h400)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(b_in_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .cpu_reset_n(b_cpu_reset_n), .busy(b_busy), .done(b_done), .error(b_error), .word_count(b_word_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] wq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin : mon_a
    exp_t e;
    if (imem_we) begin
      if (qa.size() == 0) chk("a_unexp_we", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_addr", imem_addr, e.addr);
        chk("a_data", imem_wdata, e.data);
        chk("a_cnt", {16'd0, word_count}, {16'd0, e.cnt});
      end
    end
  end

  always @(negedge clock) begin : mon_b
    exp_t e;
    if (b_imem_we) begin
      if (qb.size() == 0) chk("b_unexp_we", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_addr", b_imem_addr, e.addr);
        chk("b_data", b_imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit st);
    in_valid = 1'b1;
    in_byte  = b;
    start    = st;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    if (gap) begin
      in_byte = 8'h5A;
      tick();
    end
  endtask

  // header + data for the words in wq; mid_start = byte index that also raises start
  task automatic load(input bit gap, input int mid_start);
    logic [15:0] nn;
    logic [31:0] w;
    exp_t        e;
    nn = 16'(wq.size());
    send_byte(nn[15:8], gap, 1'b0);
    send_byte(nn[7:0], gap, 1'b0);
    for (int k = 0; k < wq.size(); k++) begin
      w      = wq[k];
      e.data = w;
      e.cnt  = 16'(k + 1);
      e.addr = 32'(4 * k);
      qa.push_back(e);
      e.addr = 32'h400 + 32'(4 * k);
      qb.push_back(e);
      for (int b = 0; b < 4; b++)
        send_byte(w[31-8*b -: 8], gap, bit'(mid_start == 4 * k + b));
    end
  endtask

  task automatic finish_chk(input logic [15:0] n);
    int i;
    i = 0;
    while (!done && i < 20) begin
      tick();
      i++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("fin_count", {16'd0, word_count}, {16'd0, n});
    chk("cpu_rst_entry", {31'd0, cpu_reset_n}, 32'd0);
    tick();
    chk("cpu_rst_rel", {31'd0, cpu_reset_n}, 32'd1);
    chk("b_cpu_rst_rel", {31'd0, b_cpu_reset_n}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_b_addr"}, b_imem_addr, 32'h400);
    chk({tag, "_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_flags"}, {28'd0, cpu_reset_n, busy, done, error}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, word_count}, 32'd0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_error"}, {31'd0, error}, 32'd1);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_cpu"}, {31'd0, cpu_reset_n}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    // two-word program
    start_pulse();
    chk("hdr_busy", {31'd0, busy}, 32'd1);
    wq = '{32'h2008_0005, 32'h0109_5020};
    load(1'b0, -1);
    finish_chk(16'd2);

    // zero-length header from FIN
    start_pulse();
    chk("restart_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    chk_err("n0");
    tick();

    // N = 257 exceeds DEPTH
    start_pulse();
    chk("restart_err", {31'd0, error}, 32'd0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    chk_err("n257");
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    tick();
    in_valid = 1'b0;
    chk_err("n257_hold");

    // in_valid gaps
    start_pulse();
    wq = '{32'hA1B2_C3D4};
    load(1'b1, -1);
    finish_chk(16'd1);

    // reset mid-word abandons the load
    start_pulse();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    repeat (2) tick();
    start_pulse();
    wq = '{32'hDEAD_BEEF};
    load(1'b0, -1);
    finish_chk(16'd1);

    // start mid-DATA is ignored
    start_pulse();
    wq = '{32'h1357_9BDF, 32'h2468_ACE0};
    load(1'b0, 5);
    finish_chk(16'd2);

    // start in FIN drops cpu reset and reloads from base
    start_pulse();
    chk("fin_restart_done", {31'd0, done}, 32'd0);
    chk("fin_restart_cpu", {31'd0, cpu_reset_n}, 32'd0);
    chk("fin_restart_cnt", {16'd0, word_count}, 32'd0);
    wq = '{32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h1234_5678};
    load(1'b0, -1);
    finish_chk(16'd3);

    // full-depth image
    start_pulse();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    load(1'b0, -1);
    finish_chk(16'd256);

    repeat (3) tick();
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
